// File: rtl/hit_receiver_pkg.sv
// Shared definitions for the defender-side hit receiver: attack word layout,
// damage table, FSM states and knockback/velocity vector field positions.
package hit_receiver_pkg;

    // Attack status word bit positions
    localparam int HIT     = 0;
    localparam int SMASH_U = 1;
    localparam int SMASH_D = 2;
    localparam int SMASH_L = 3;
    localparam int SMASH_R = 4;
    localparam int JAB     = 5;
    localparam int SPEC_U  = 6;
    localparam int SPEC_D  = 7;
    localparam int SPEC_L  = 8;
    localparam int SPEC_R  = 9;
    localparam int SPEC_N  = 10;
    localparam int ANY     = 11;

    // Damage applied per attack type
    localparam logic [3:0] DMG_SMASH    = 4'd15;
    localparam logic [3:0] DMG_JAB      = 4'd3;
    localparam logic [3:0] DMG_SPEC_DIR = 4'd10;
    localparam logic [3:0] DMG_SPEC_N   = 4'd8;
    localparam logic [3:0] DMG_NONE     = 4'd1;

    // Receiver FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        STUN = 2'd2
    } rxState_t;

    // Vector field slices: X in the upper half, Y in the lower half
    localparam int X_MSB = 31;
    localparam int X_LSB = 16;
    localparam int Y_MSB = 15;
    localparam int Y_LSB = 0;

    // Damage table lookup; the groups are contiguous and ascending, so testing
    // them in order gives "lowest set type bit wins".
    function automatic logic [3:0] damageAmount(input logic [SPEC_N:SMASH_U] typeBits);
        if (|typeBits[SMASH_R:SMASH_U])     return DMG_SMASH;
        else if (typeBits[JAB])             return DMG_JAB;
        else if (|typeBits[SPEC_R:SPEC_U])  return DMG_SPEC_DIR;
        else if (typeBits[SPEC_N])          return DMG_SPEC_N;
        else                                return DMG_NONE;
    endfunction

endpackage

// File: rtl/hit_receiver_kb_scale.sv
// Damage-scaled knockback for one vector component:
// vel = sat16((kb * (64 + dmg)) >>> 6), floor shift, saturating to int16.
module kb_scale
    import hit_receiver_pkg::*;
(
    input  logic signed [15:0] kb,
    input  logic        [9:0]  dmg,
    output logic signed [15:0] vel
);

    logic signed [11:0] scale;
    logic signed [27:0] product;
    logic signed [27:0] shifted;

    // 64 + dmg is at most 1087, so it is always positive in 12 signed bits
    assign scale   = $signed({2'b00, dmg} + 12'd64);
    assign product = 28'(kb) * 28'(scale);
    assign shifted = product >>> 6;

    // Clamp the scaled value into the signed 16-bit velocity range
    always_comb begin
        if (shifted > 28'sd32767)
            vel = 16'sh7FFF;
        else if (shifted < -28'sd32768)
            vel = 16'sh8000;
        else
            vel = shifted[15:0];
    end

endmodule

// File: rtl/hit_receiver.sv
// Defender hit receiver: registers one hit per landed attack, accumulates
// damage, launches with damage-scaled velocity and holds hitstun while the
// velocity decays toward zero on frame ticks.
module hit_receiver
    import hit_receiver_pkg::*;
#(
    parameter int STUN_BASE = 8,
    parameter int DECAY     = 16,
    parameter int DMG_MAX   = 999
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] attack,
    input  logic [31:0] knockback,
    input  logic        tick,
    input  logic        respawn,
    output logic [15:0] damage,
    output logic [31:0] velocity,
    output logic        hitstun,
    output logic        hit_ack
);

    rxState_t           state;
    rxState_t           nextState;
    logic               prevHit;
    logic               hitEdge;
    logic [3:0]         amtLatch;
    logic [31:0]        kbLatch;
    logic [7:0]         stunCnt;
    logic [15:0]        sumDamage;
    logic [15:0]        newDamage;
    logic [7:0]         newStun;
    logic signed [15:0] velX;
    logic signed [15:0] velY;
    logic               unusedAttackBits;

    // The status flags above the type field are not needed here
    assign unusedAttackBits = ^attack[31:ANY];

    // Move one velocity component toward zero by DECAY without crossing zero
    function automatic logic [15:0] decayToward0(input logic signed [15:0] v);
        logic signed [16:0] wide;
        logic signed [16:0] step;
        wide = 17'(v);
        step = 17'(DECAY);
        if (wide > step)
            return 16'(wide - step);
        else if (wide < -step)
            return 16'(wide + step);
        else
            return 16'd0;
    endfunction

    assign hitEdge   = attack[HIT] & ~prevHit;
    assign sumDamage = damage + {12'd0, amtLatch};
    assign newDamage = (sumDamage > 16'(DMG_MAX)) ? 16'(DMG_MAX) : sumDamage;
    assign newStun   = 8'(STUN_BASE) + newDamage[11:4];

    kb_scale u_scaleX (
        .kb  (kbLatch[X_MSB:X_LSB]),
        .dmg (newDamage[9:0]),
        .vel (velX)
    );

    kb_scale u_scaleY (
        .kb  (kbLatch[Y_MSB:Y_LSB]),
        .dmg (newDamage[9:0]),
        .vel (velY)
    );

    // Previous attack[0] sample for rising-edge hit detection
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) prevHit <= 1'b0;
        else        prevHit <= attack[HIT];
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Next-state logic; respawn wins over hits and ticks, hits during CALC/STUN are dropped
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        nextState = state;
        if (respawn) begin
            nextState = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (hitEdge) nextState = CALC;
                CALC:    nextState = STUN;
                STUN:    if (tick && stunCnt == 8'd1) nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    // Hit latch, damage/velocity/stun update and registered status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            damage   <= '0;
            velocity <= '0;
            stunCnt  <= '0;
            hit_ack  <= 1'b0;
            hitstun  <= 1'b0;
            amtLatch <= '0;
            kbLatch  <= '0;
        end else begin
            hit_ack <= 1'b0;
            hitstun <= (nextState == STUN);
            if (respawn) begin
                damage   <= '0;
                velocity <= '0;
                stunCnt  <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (hitEdge) begin
                            amtLatch <= damageAmount(attack[SPEC_N:SMASH_U]);
                            kbLatch  <= knockback;
                        end
                    end
                    CALC: begin
                        damage   <= newDamage;
                        velocity <= {velX, velY};
                        stunCnt  <= newStun;
                        hit_ack  <= 1'b1;
                    end
                    STUN: begin
                        if (tick) begin
                            stunCnt <= stunCnt - 8'd1;
                            if (stunCnt == 8'd1)
                                velocity <= '0;
                            else
                                velocity <= {decayToward0($signed(velocity[X_MSB:X_LSB])),
                                             decayToward0($signed(velocity[Y_MSB:Y_LSB]))};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
